// File: rtl/rb_alloc_ctrl_pkg.sv
// Shared types and sizing for the value-skip Result Buffer allocation logic.
// Everything that depends on the RB geometry is derived from the constants here.
package rb_alloc_ctrl_pkg;

  localparam int RESULT_BUFFER_SIZE    = 8;
  localparam int RESULT_BUFFER_ID_SIZE = $clog2(RESULT_BUFFER_SIZE);
  localparam int REFCNT_WIDTH          = 3;
  localparam int PTR_REG_ID_WIDTH      = 5;
  localparam int RB_DATA_WIDTH         = 32;

  typedef enum logic [1:0] {
    RB_FREE    = 2'd0,
    RB_PENDING = 2'd1,
    RB_READY   = 2'd2
  } RBStateType;

  typedef struct packed {
    logic                             Enable;
    logic [RESULT_BUFFER_ID_SIZE-1:0] RBIdx;
  } RBPickupType;

  typedef struct packed {
    RBStateType                  state;
    logic [REFCNT_WIDTH-1:0]     refcnt;
    logic [PTR_REG_ID_WIDTH-1:0] pointerRegId;
    logic [RB_DATA_WIDTH-1:0]    result;
  } RBEntryStateType;

endpackage

// File: rtl/rb_alloc_ctrl_free_pick.sv
// Lowest-set-bit priority encoder over the FREE vector of the Result Buffer.
// found_o is low when no entry is free; idx_o is then zero and meaningless.
module rb_free_pick
  import rb_alloc_ctrl_pkg::*;
#(
  parameter int N  = RESULT_BUFFER_SIZE,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  free_vec_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Scanning downward lets the lowest free index overwrite any higher one.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_vec_i[i]) idx_o = IW'(i);
    end
  end

  assign found_o = |free_vec_i;

endmodule

// File: rtl/rb_alloc_ctrl.sv
// Result Buffer allocation and lifetime controller: hands out free entries,
// takes write-backs, serves registered pickups and reference-counts each entry.
module rb_alloc_ctrl
  import rb_alloc_ctrl_pkg::*;
(
  input  logic                               clk,
  input  logic                               nRst,
  input  logic                               alloc_req,
  input  logic [PTR_REG_ID_WIDTH-1:0]        alloc_ptrRegId,
  output logic                               alloc_gnt,
  output logic [RESULT_BUFFER_ID_SIZE-1:0]   alloc_idx,
  input  logic                               retain_en,
  input  logic [RESULT_BUFFER_ID_SIZE-1:0]   retain_idx,
  input  logic                               release_en,
  input  logic [RESULT_BUFFER_ID_SIZE-1:0]   release_idx,
  input  logic                               wb_en,
  input  logic [RESULT_BUFFER_ID_SIZE-1:0]   wb_idx,
  input  logic [RB_DATA_WIDTH-1:0]           wb_data,
  input  RBPickupType                        pickup,
  output logic                               pickup_valid,
  output logic                               pickup_stall,
  output logic [RB_DATA_WIDTH-1:0]           pickup_data,
  output logic [PTR_REG_ID_WIDTH-1:0]        pickup_ptrRegId,
  input  logic                               flush,
  output logic [RESULT_BUFFER_ID_SIZE:0]     free_count,
  output logic                               full,
  output logic                               err
);

  localparam int N  = RESULT_BUFFER_SIZE;
  localparam int IW = RESULT_BUFFER_ID_SIZE;
  localparam int CW = RESULT_BUFFER_ID_SIZE + 1;
  localparam logic [REFCNT_WIDTH-1:0] REFCNT_MAX = '1;

  RBEntryStateType              entry_q [N];
  RBEntryStateType              entry_d [N];
  logic                         err_q, err_d;
  logic                         pickup_valid_q, pickup_valid_d;
  logic                         pickup_stall_q, pickup_stall_d;
  logic [RB_DATA_WIDTH-1:0]     pickup_data_q, pickup_data_d;
  logic [PTR_REG_ID_WIDTH-1:0]  pickup_ptr_q, pickup_ptr_d;

  logic [N-1:0]                 free_vec;
  logic                         free_found;
  logic [IW-1:0]                free_idx;

  RBEntryStateType              ret_e, rel_e, wb_e, pk_e;
  logic                         same_ret_rel;
  logic                         ret_ok, rel_ok, wb_ok, pk_bypass;
  logic                         ret_err, rel_err, wb_err, alloc_err, pk_err;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      free_vec[i] = (entry_q[i].state == RB_FREE);
    end
  end

  rb_free_pick #(
    .N  (N),
    .IW (IW)
  ) u_free_pick (
    .free_vec_i (free_vec),
    .found_o    (free_found),
    .idx_o      (free_idx)
  );

  // Allocation is decided purely from start-of-cycle state, so an entry freed
  // this cycle can only be handed out from the next cycle on.
  assign full      = ~free_found;
  assign alloc_gnt = alloc_req & free_found & ~flush & nRst;
  assign alloc_idx = free_idx;

  assign ret_e = entry_q[retain_idx];
  assign rel_e = entry_q[release_idx];
  assign wb_e  = entry_q[wb_idx];
  assign pk_e  = entry_q[pickup.RBIdx];

  // A retain paired with a release on the same entry is a net no-op, so it
  // cannot overflow even when the counter is already saturated.
  assign same_ret_rel = retain_en & release_en & (retain_idx == release_idx);
  assign ret_ok  = retain_en & (ret_e.state != RB_FREE) & ((ret_e.refcnt != REFCNT_MAX) | same_ret_rel);
  assign rel_ok  = release_en & (rel_e.state != RB_FREE);
  assign wb_ok   = wb_en & (wb_e.state == RB_PENDING);
  assign ret_err = retain_en & ~ret_ok;
  assign rel_err = release_en & ~rel_ok;
  assign wb_err  = wb_en & ~wb_ok;
  assign alloc_err = alloc_gnt & ((retain_en & (retain_idx == free_idx)) |
                                  (release_en & (release_idx == free_idx)));
  assign pk_bypass = wb_ok & (wb_idx == pickup.RBIdx);
  assign pk_err    = pickup.Enable & (pk_e.state == RB_FREE);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the same pre-edge values regardless of statement order.
    if (!nRst) begin
      // NOTE: the entry array is reset explicitly because result and
      // pointerRegId must read back as zero after reset.
      for (int i = 0; i < N; i++) entry_q[i] <= '0;
      err_q          <= 1'b0;
      pickup_valid_q <= 1'b0;
      pickup_stall_q <= 1'b0;
      pickup_data_q  <= '0;
      pickup_ptr_q   <= '0;
    end else begin
      for (int i = 0; i < N; i++) entry_q[i] <= entry_d[i];
      err_q          <= err_d;
      pickup_valid_q <= pickup_valid_d;
      pickup_stall_q <= pickup_stall_d;
      pickup_data_q  <= pickup_data_d;
      pickup_ptr_q   <= pickup_ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    logic                    inc, dec;
    logic [REFCNT_WIDTH-1:0] refcnt_nxt;
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned and no latch is inferred.
    inc            = 1'b0;
    dec            = 1'b0;
    refcnt_nxt     = '0;
    err_d          = err_q | ret_err | rel_err | wb_err | alloc_err | pk_err;
    pickup_valid_d = 1'b0;
    pickup_stall_d = 1'b0;
    pickup_data_d  = pickup_data_q;
    pickup_ptr_d   = pickup_ptr_q;

    for (int i = 0; i < N; i++) begin
      entry_d[i] = entry_q[i];
      inc = ret_ok & (retain_idx == IW'(i));
      dec = rel_ok & (release_idx == IW'(i));
      if (entry_q[i].state == RB_FREE) begin
        if (alloc_gnt && (free_idx == IW'(i))) begin
          entry_d[i].state        = RB_PENDING;
          entry_d[i].refcnt       = REFCNT_WIDTH'(1);
          entry_d[i].pointerRegId = alloc_ptrRegId;
        end
      end else begin
        if (wb_ok && (wb_idx == IW'(i))) begin
          entry_d[i].result = wb_data;
          entry_d[i].state  = RB_READY;
        end
        refcnt_nxt = entry_q[i].refcnt + REFCNT_WIDTH'(inc) - REFCNT_WIDTH'(dec);
        entry_d[i].refcnt = refcnt_nxt;
        if (refcnt_nxt == '0) entry_d[i].state = RB_FREE;
      end
    end

    // Pickup sees start-of-cycle state, plus a same-cycle write-back bypass.
    if (pickup.Enable) begin
      unique case (pk_e.state)
        RB_READY: begin
          pickup_valid_d = 1'b1;
          pickup_data_d  = pk_e.result;
          pickup_ptr_d   = pk_e.pointerRegId;
        end
        RB_PENDING: begin
          pickup_valid_d = pk_bypass;
          pickup_stall_d = ~pk_bypass;
          pickup_data_d  = pk_bypass ? wb_data : '0;
          pickup_ptr_d   = pk_e.pointerRegId;
        end
        default: begin
          pickup_data_d = '0;
          pickup_ptr_d  = '0;
        end
      endcase
    end

    if (flush) begin
      for (int i = 0; i < N; i++) entry_d[i] = '0;
      err_d          = 1'b0;
      pickup_valid_d = 1'b0;
      pickup_stall_d = 1'b0;
      pickup_data_d  = '0;
      pickup_ptr_d   = '0;
    end
  end

  // Output logic
  always_comb begin
    free_count = '0;
    for (int i = 0; i < N; i++) begin
      free_count = free_count + CW'(free_vec[i]);
    end
  end

  assign pickup_valid    = pickup_valid_q;
  assign pickup_stall    = pickup_stall_q;
  assign pickup_data     = pickup_data_q;
  assign pickup_ptrRegId = pickup_ptr_q;
  assign err             = err_q;

endmodule
